// File: rtl/code_1.sv
// Registered two-operand AND/OR/XOR/ADD unit with one pipeline stage.
// Optional macro CODE_1_SAT_EN: ADD saturates to all-ones instead of wrapping.
module code_1 #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic             carry
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] c_d, c_q;
  logic             carry_d, carry_q;
  logic             valid_q;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    c_d     = '0;
    carry_d = 1'b0;
    unique case (op_e'(op))
      OP_AND: c_d = a & b;
      OP_OR:  c_d = a | b;
      OP_XOR: c_d = a ^ b;
      OP_ADD: begin
        carry_d = sum[WIDTH];
`ifdef CODE_1_SAT_EN
        c_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        c_d = sum[WIDTH-1:0];
`endif
      end
      default: c_d = '0;
    endcase
  end

  // Result and carry load only on accepted inputs so idle cycles hold them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q     <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        c_q     <= c_d;
        carry_q <= carry_d;
      end
    end
  end

  assign c         = c_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_code_1.sv
// Directed table-driven bench for code_1; expectations follow CODE_1_SAT_EN when defined.
module tb_code_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] op;
  logic [2:0] a, b;
  logic [2:0] c;
  logic       out_valid, carry;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] AND_ = 2'b00, OR_ = 2'b01, XOR_ = 2'b10, ADD_ = 2'b11;

`ifdef CODE_1_SAT_EN
  localparam logic [2:0] OVF_111_001 = 3'b111;
  localparam logic [2:0] OVF_110_011 = 3'b111;
`else
  localparam logic [2:0] OVF_111_001 = 3'b000;
  localparam logic [2:0] OVF_110_011 = 3'b001;
`endif

  code_1 #(.WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       vld;
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] exp_c;
    logic       exp_carry;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] ec, input logic ecy, input logic eov);
    chk({name, ".c"}, int'(c), int'(ec));
    chk({name, ".carry"}, int'(carry), int'(ecy));
    chk({name, ".out_valid"}, int'(out_valid), int'(eov));
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] o,
                       input logic [2:0] av, input logic [2:0] bv);
    rst_n = r; in_valid = v; op = o; a = av; b = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"add_1_0",      1'b1, ADD_, 3'b001, 3'b000, 3'b001, 1'b0, 1'b1};
    vecs[1]  = '{"add_5_1",      1'b1, ADD_, 3'b101, 3'b001, 3'b110, 1'b0, 1'b1};
    vecs[2]  = '{"or_1_4",       1'b1, OR_,  3'b001, 3'b100, 3'b101, 1'b0, 1'b1};
    vecs[3]  = '{"and_5_1",      1'b1, AND_, 3'b101, 3'b001, 3'b001, 1'b0, 1'b1};
    vecs[4]  = '{"xor_5_1",      1'b1, XOR_, 3'b101, 3'b001, 3'b100, 1'b0, 1'b1};
    vecs[5]  = '{"add_7_1_ovf",  1'b1, ADD_, 3'b111, 3'b001, OVF_111_001, 1'b1, 1'b1};
    vecs[6]  = '{"add_6_3_ovf",  1'b1, ADD_, 3'b110, 3'b011, OVF_110_011, 1'b1, 1'b1};
    vecs[7]  = '{"and_clr_cy",   1'b1, AND_, 3'b111, 3'b010, 3'b010, 1'b0, 1'b1};
    vecs[8]  = '{"add_3_4_edge", 1'b1, ADD_, 3'b011, 3'b100, 3'b111, 1'b0, 1'b1};
    vecs[9]  = '{"idle_hold",    1'b0, XOR_, 3'b010, 3'b110, 3'b111, 1'b0, 1'b0};
    vecs[10] = '{"xor_7_7",      1'b1, XOR_, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1};

    // Reset held two cycles with a valid input present.
    drive(1'b0, 1'b1, ADD_, 3'b101, 3'b001);
    chk_all("reset1", 3'b000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, ADD_, 3'b101, 3'b001);
    chk_all("reset2", 3'b000, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].vld, vecs[i].op, vecs[i].a, vecs[i].b);
      chk_all(vecs[i].name, vecs[i].exp_c, vecs[i].exp_carry, vecs[i].exp_ov);
    end

    // Hold: overflow result, then three idle cycles with random operands.
    drive(1'b1, 1'b1, ADD_, 3'b111, 3'b001);
    chk_all("hold_src", OVF_111_001, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
      chk_all($sformatf("hold%0d", i), OVF_111_001, 1'b1, 1'b0);
    end

    // Reset mid-stream drops the concurrent input.
    drive(1'b1, 1'b1, ADD_, 3'b011, 3'b010);
    chk_all("pre_rst", 3'b101, 1'b0, 1'b1);
    drive(1'b0, 1'b1, ADD_, 3'b011, 3'b010);
    chk_all("mid_rst", 3'b000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, ADD_, 3'b011, 3'b010);
    chk_all("post_rst_idle", 3'b000, 1'b0, 1'b0);
    drive(1'b1, 1'b1, OR_, 3'b010, 3'b001);
    chk_all("post_rst_first", 3'b011, 1'b0, 1'b1);
    drive(1'b1, 1'b0, AND_, 3'b000, 3'b000);
    chk_all("post_rst_gap", 3'b011, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_1.md
# code_1

Small registered 3-bit two-operand logic/arithmetic unit. Each cycle with `in_valid` high, it combines operands `a` and `b` according to `op` and registers the result on `c` one clock later. It is a leaf datapath block, driven by a local controller and consumed by downstream logic that samples `c` when `out_valid` is high.

## Interface
- `WIDTH`, default 3: operand and result width; all requirements below are stated for `WIDTH` = 3, and generalise to modulo 2^`WIDTH` arithmetic.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  reset; synchronous, active-low, sampled on the rising edge of `clk`.
- `in_valid`  input  1  operands and `op` valid this cycle.
- `op`  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 ADD.
- `a`  input  WIDTH  operand A, unsigned.
- `b`  input  WIDTH  operand B, unsigned.
- `c`  output  WIDTH  registered result.
- `out_valid`  output  1  `c` holds a new result this cycle.
- `carry`  output  1  registered carry-out of ADD; 0 for logic ops.

## Operation
- AND: `c` = `a` & `b` bitwise.
- OR: `c` = `a` | `b` bitwise.
- XOR: `c` = `a` ^ `b` bitwise.
- ADD: 4-bit sum `a` + `b`. `carry` = sum[3]. `c` = sum[2:0] (wrap) or saturated; see Configuration.
- Logic ops force `carry` to 0.
- When `in_valid` = 0: `c` and `carry` hold their previous values, and `out_valid` = 0 on the next cycle.
- No backpressure: every accepted input produces exactly one `out_valid` pulse. No state machine; single pipeline register stage.
- `a`, `b` and `op` are don't-care when `in_valid` = 0. They must not alter any output.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N appear on `c`/`carry`, with `out_valid` = 1, after edge N, for one cycle.
- Back-to-back `in_valid` gives one result per cycle, and `out_valid` stays high continuously.
- Reset: with `rst_n` = 0 at a rising edge, `c` = 0, `carry` = 0 and `out_valid` = 0 after that edge, regardless of `in_valid`.
- Reset mid-stream: an input presented in the same cycle as reset is dropped. The first result after reset release comes from the first `in_valid` cycle with `rst_n` = 1.
- Outputs are driven only from flops; no combinational path from inputs to outputs.

## Configuration
- Macro `CODE_1_SAT_EN`.
- Defined: ADD saturates. When sum > 7, `c` = 3'b111 and `carry` = 1.
- Undefined (default): ADD wraps modulo 8. `c` = sum[2:0] and `carry` = sum[3].
- Logic ops and all timing are identical in both builds.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `in_valid` = 1, `a` = 3'b101, `b` = 3'b001 -> `c` = 0, `carry` = 0, `out_valid` = 0.
- ADD, no overflow: `a` = 001, `b` = 000, then `a` = 101, `b` = 001, back-to-back -> `c` = 001 then `c` = 110, `carry` = 0, `out_valid` high for both cycles.
- Logic ops:
  - `a` = 001, `b` = 100, OR -> `c` = 101.
  - `a` = 101, `b` = 001, AND -> `c` = 001.
  - `a` = 101, `b` = 001, XOR -> `c` = 100.
  - `carry` = 0 in all three cases.
- Overflow: `a` = 111, `b` = 001, ADD -> without macro `c` = 000, `carry` = 1; with `CODE_1_SAT_EN` `c` = 111, `carry` = 1.
- Hold: a valid result, then 3 cycles of `in_valid` = 0 with random `a`/`b`/`op` -> `c` and `carry` unchanged, `out_valid` = 0.
- Reset mid-stream: `in_valid` = 1 with `a` = 011, `b` = 010, ADD, in the same cycle as `rst_n` = 0 -> next cycle `c` = 0, `out_valid` = 0; the input is dropped.
